// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART: parity modes, FSM state
// encoding and baud-divider helpers.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Never returns less than 1 so an illegal DIV still elaborates far enough to report it.
  function automatic int calc_div_w(input int clk_freq, input int baud);
    int d;
    d = clk_freq / baud;
    return (d < 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Byte-stream handshake into the transmitter. A word moves on a rising clock
// edge where s_valid and s_ready are both high; s_data must be stable while s_valid is high.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_BITS-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Restartable 0..DIV-1 divider; bit_tick marks the last clock of each bit period.
// Shared by the transmitter and the planned configurable receiver.
module uart_bit_timer #(
  parameter int DIV   = 10,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic bit_tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_tick = !restart && (cnt == LAST);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (DATA_BITS, PARITY, STOP_BITS fixed at elaboration).
// Optional macro UART_TX_CTS_EN adds the active-low cts_n input that gates accepts.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef UART_TX_CTS_EN
  input  logic        cts_n,
`endif
  uart_tx_cfg_if.slave s,
  output logic        tx,
  output logic        tx_busy,
  output logic        frame_done,
  output uart_state_t dbg_state
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int CNT_W = calc_div_w(CLK_FREQ, BAUD);
  localparam int BC_W  = $clog2(DATA_BITS);

  generate
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_cfg: CLK_FREQ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("uart_tx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_par
      $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  uart_state_t          state, state_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [BC_W-1:0]      bit_cnt, bit_cnt_n;
  logic                 stop_cnt, stop_cnt_n;
  logic                 par_bit, par_n;
  logic                 tx_n;
  logic                 restart;
  logic                 bit_tick;
  logic                 ready;
  logic                 accept;

  uart_bit_timer #(
    .DIV   (DIV),
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .restart  (restart),
    .bit_tick (bit_tick)
  );

  // Reset gates ready directly because the state register already sits in IDLE while held.
`ifdef UART_TX_CTS_EN
  assign ready = reset_n && (state == ST_IDLE) && !cts_n;
`else
  assign ready = reset_n && (state == ST_IDLE);
`endif

  assign accept    = s.s_valid && ready;
  assign s.s_ready = ready;
  assign tx_busy   = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      par_bit  <= par_n;
      tx       <= tx_n;
    end
  end

  // tx_n is the line level for the next clock, so tx itself comes straight from a flop.
  always_comb begin
    state_n    = state;
    shift_n    = shift;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    par_n      = par_bit;
    tx_n       = tx;
    restart    = 1'b0;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_n = 1'b1;
        if (accept) begin
          shift_n = s.s_data;
          par_n   = (PARITY == PAR_ODD) ? ~^s.s_data : ^s.s_data;
          restart = 1'b1;
          tx_n    = 1'b0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          bit_cnt_n = '0;
          tx_n      = shift[0];
          state_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_cnt == BC_W'(DATA_BITS - 1)) begin
            if (PARITY != PAR_NONE) begin
              tx_n    = par_bit;
              state_n = ST_PARITY;
            end else begin
              stop_cnt_n = 1'b0;
              tx_n       = 1'b1;
              state_n    = ST_STOP;
            end
          end else begin
            shift_n   = shift >> 1;
            tx_n      = shift_n[0];
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          stop_cnt_n = 1'b0;
          tx_n       = 1'b1;
          state_n    = ST_STOP;
        end
      end
      ST_STOP: begin
        tx_n = 1'b1;
        if (bit_tick) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            frame_done = 1'b1;
            state_n    = ST_IDLE;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule
